bus_arbiter_rr: RTL
===================

Name: bus_arbiter_rr

Overview:
- N-master, single-slave memory bus arbiter. Successor to the fixed two-port combinational arbiter.
- Adds parametrised master count and widths, round-robin or fixed priority, and a registered grant held across multi-cycle slave transactions.
- Slave completion is signalled by ready_in.
- Sits between the CPU instruction/data ports (plus future DMA/debug masters) and the memory/peripheral interconnect.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (>=2); master 0 = lowest index.
- ADDR_WIDTH, 64, address width.
- DATA_WIDTH, 64, data width (multiple of 8).
- MASK_WIDTH, DATA_WIDTH/8, byte write mask width.
- PRIORITY_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins).

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- m_address_in  in  NUM_MASTERS*ADDR_WIDTH  per-master address, master i at slice i.
- m_read_in  in  NUM_MASTERS  per-master read request.
- m_write_in  in  NUM_MASTERS  per-master write request.
- m_write_mask_in  in  NUM_MASTERS*MASK_WIDTH  per-master byte mask.
- m_write_value_in  in  NUM_MASTERS*DATA_WIDTH  per-master write data.
- m_read_value_out  out  NUM_MASTERS*DATA_WIDTH  per-master read data.
- m_ready_out  out  NUM_MASTERS  per-master one-cycle completion strobe.
- address_out  out  ADDR_WIDTH  slave address.
- read_out  out  1  slave read strobe.
- write_out  out  1  slave write strobe.
- write_mask_out  out  MASK_WIDTH  slave byte mask.
- write_value_out  out  DATA_WIDTH  slave write data.
- read_value_in  in  DATA_WIDTH  slave read data, valid when ready_in=1.
- ready_in  in  1  slave completion, may be held low for any number of cycles.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Request definition: req[i] = m_read_in[i] | m_write_in[i]. A master holds its request and payload stable until m_ready_out[i].
- State register: IDLE/BUSY, plus grant index GW = max(1, $clog2(NUM_MASTERS)) and round-robin pointer rr_ptr (GW bits).
- Reset: state=IDLE, grant=0, rr_ptr=0. All outputs 0: read_out, write_out, write_mask_out, address_out, write_value_out, m_ready_out, m_read_value_out. No X is driven on any output, ever.
- IDLE: slave strobes 0, mask 0, m_ready_out 0.
  - If any req, pick winner, register it in grant, go BUSY.
  - RR mode: winner is the first requester at index >= rr_ptr, wrapping modulo NUM_MASTERS.
  - Fixed mode: winner is the lowest requesting index.
- BUSY: slave outputs are combinationally muxed from the granted master's address, read, write, mask and write value.
  - m_read_value_out slice[grant] = read_value_in; all other slices 0.
  - If ready_in=1: m_ready_out[grant]=1 this cycle; RR mode sets rr_ptr = (grant+1) mod NUM_MASTERS (wrap at NUM_MASTERS-1 -> 0); next state IDLE.
  - If ready_in=0: stay BUSY, grant unchanged, no m_ready_out.
- Latency and throughput:
  - Request to first slave strobe: 1 cycle.
  - Request to m_ready_out: 1 + slave latency, minimum 2 cycles.
  - One mandatory IDLE cycle between transactions: max 1 transaction per 2 cycles.
- Abort: if the granted master drops req in BUSY without ready_in, go IDLE next cycle. Slave strobes follow the master (drop same cycle), no m_ready_out, rr_ptr unchanged.
- Simultaneous events:
  - Requests arriving while BUSY wait; no preemption.
  - ready_in=1 in IDLE is ignored.
  - If both read and write are asserted by one master, both are forwarded unchanged; the slave resolves.
- Reset mid-transaction: on the next edge, state=IDLE and all outputs 0. The in-flight transaction is dropped without m_ready_out.
- NUM_MASTERS not a power of two: pointer and grant never take values >= NUM_MASTERS.

Decomposition:
- bus_arbiter_pkg holds:
  - state enum (ARB_IDLE, ARB_BUSY);
  - constants PRIO_ROUND_ROBIN=0, PRIO_FIXED=1;
  - grant-width helper function.
- Sub-module rr_priority_picker: purely combinational.
  - Inputs: req vector, start pointer, mode.
  - Outputs: winner index and any_req.
  - Reusable by future interrupt/DMA arbiters.

Test Plan:
- Reset then idle, NUM_MASTERS=2: all outputs 0 for 10 cycles, no X anywhere.
- RR fairness, N=3, masters 0,1,2 requesting continuously, ready_in=1 every BUSY cycle: grants 0,1,2,0,1,2. m_ready_out strobes every 2 cycles, one-hot.
- Fixed mode, N=3, masters 0 and 2 continuously requesting: master 0 wins every transaction; master 2 never granted while master 0 requests.
- Wait states: master 1 reads address 0x1000, ready_in low 3 cycles then high with read_value_in=0xDEADBEEF:
  - read_out=1 for 4 cycles;
  - m_ready_out[1] exactly once, on cycle 5 after the request;
  - slice 1 of m_read_value_out = 0xDEADBEEF that cycle.
- Write pass-through: master 0 writes mask 0x0F, value 0x1122334455667788 to 0x20 -> address_out=0x20, write_out=1, write_mask_out=0x0F, write_value_out matches, read_out=0.
- Abort and reset: master 0 drops request in BUSY -> IDLE next cycle, no ready strobe, rr_ptr unchanged. Reset asserted mid-BUSY -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// Shared types and helpers for the round-robin / fixed-priority bus arbiter.
//   arb_state_e       : arbiter FSM state (ARB_IDLE, ARB_BUSY)
//   PRIO_ROUND_ROBIN  : PRIORITY_MODE value for rotating priority
//   PRIO_FIXED        : PRIORITY_MODE value for lowest-index-wins priority
//   grant_width()     : bits needed to hold a master index, never less than 1
package bus_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    localparam int PRIO_ROUND_ROBIN = 0;
    localparam int PRIO_FIXED       = 1;

    function automatic int grant_width(input int num_masters);
        return (num_masters > 2) ? $clog2(num_masters) : 1;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_if.sv
// Bundle of the arbiter's request-side and slave-side bus signals.
//   m_*_in / m_*_out : per-master request payload and completion, master i at slice i
//   *_out / *_in     : single downstream slave bus
// Modports:
//   master : arbiter view (it is the bus master of the downstream slave)
//   slave  : environment view (requesting masters plus the memory/peripheral slave)
// Handshake: a master raises read and/or write with a stable payload and holds
// it until its m_ready_out bit strobes for one cycle; the slave completes the
// granted transfer by raising ready_in, with read_value_in valid in that cycle.
interface bus_arbiter_rr_if #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_WIDTH  = 64,
    parameter int DATA_WIDTH  = 64,
    parameter int MASK_WIDTH  = DATA_WIDTH / 8
);
    logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_address_in;
    logic [NUM_MASTERS-1:0]            m_read_in;
    logic [NUM_MASTERS-1:0]            m_write_in;
    logic [NUM_MASTERS*MASK_WIDTH-1:0] m_write_mask_in;
    logic [NUM_MASTERS*DATA_WIDTH-1:0] m_write_value_in;
    logic [NUM_MASTERS*DATA_WIDTH-1:0] m_read_value_out;
    logic [NUM_MASTERS-1:0]            m_ready_out;

    logic [ADDR_WIDTH-1:0]             address_out;
    logic                              read_out;
    logic                              write_out;
    logic [MASK_WIDTH-1:0]             write_mask_out;
    logic [DATA_WIDTH-1:0]             write_value_out;
    logic [DATA_WIDTH-1:0]             read_value_in;
    logic                              ready_in;

    modport master (
        input  m_address_in, m_read_in, m_write_in, m_write_mask_in, m_write_value_in,
        input  read_value_in, ready_in,
        output m_read_value_out, m_ready_out,
        output address_out, read_out, write_out, write_mask_out, write_value_out
    );

    modport slave (
        output m_address_in, m_read_in, m_write_in, m_write_mask_in, m_write_value_in,
        output read_value_in, ready_in,
        input  m_read_value_out, m_ready_out,
        input  address_out, read_out, write_out, write_mask_out, write_value_out
    );

endinterface

// File: rtl/rr_priority_picker.sv
// Combinational priority picker, reusable by any rotating or fixed arbiter.
//   req        : request vector, bit i = requester i
//   start_ptr  : first index considered in rotating mode (must be < NUM_REQ)
//   fixed_mode : 1 = lowest requesting index wins, start_ptr ignored
//   winner     : index of the chosen requester (0 when none)
//   any_req    : at least one request is present
module rr_priority_picker #(
    parameter int NUM_REQ = 2,
    parameter int GW      = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GW-1:0]      start_ptr,
    input  logic               fixed_mode,
    output logic [GW-1:0]      winner,
    output logic               any_req
);
    logic [GW-1:0] start;
    logic [GW-1:0] winner_hi;
    logic [GW-1:0] winner_lo;
    logic          hit_hi;

    assign start   = fixed_mode ? '0 : start_ptr;
    assign any_req = |req;

    // Scan high to low so the lowest qualifying index is the last one written.
    // winner_hi covers indices at or above start; winner_lo is the wrap-around.
    always_comb begin
        winner_hi = '0;
        winner_lo = '0;
        hit_hi    = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                winner_lo = GW'(i);
                if (i >= int'(start)) begin
                    winner_hi = GW'(i);
                    hit_hi    = 1'b1;
                end
            end
        end
        winner = hit_hi ? winner_hi : winner_lo;
    end

endmodule

// File: rtl/bus_arbiter_rr.sv
// N-master, single-slave memory bus arbiter with a grant held across
// multi-cycle slave transactions.
//   clk, reset : clock and synchronous active-high reset
//   bus        : request side and slave side signals (bus_arbiter_rr_if.master)
//   state_dbg  : current FSM state
//   grant_dbg  : registered grant index
//   rr_ptr_dbg : round-robin start pointer
// In BUSY the slave bus is a combinational mux of the granted master, so a
// master that drops its request takes the slave strobes down in the same cycle
// and the arbiter returns to IDLE without a completion strobe.
module bus_arbiter_rr
    import bus_arbiter_pkg::*;
#(
    parameter int  NUM_MASTERS   = 2,
    parameter int  ADDR_WIDTH    = 64,
    parameter int  DATA_WIDTH    = 64,
    parameter int  MASK_WIDTH    = DATA_WIDTH / 8,
    parameter int  PRIORITY_MODE = PRIO_ROUND_ROBIN,
    localparam int GW            = grant_width(NUM_MASTERS)
) (
    input  logic             clk,
    input  logic             reset,
    bus_arbiter_rr_if.master bus,
    output arb_state_e       state_dbg,
    output logic [GW-1:0]    grant_dbg,
    output logic [GW-1:0]    rr_ptr_dbg
);
    arb_state_e             state;
    logic [GW-1:0]          grant;
    logic [GW-1:0]          rr_ptr;
    logic [GW-1:0]          winner;
    logic                   any_req;
    logic                   grant_req;
    logic [NUM_MASTERS-1:0] req;

    assign req = bus.m_read_in | bus.m_write_in;

    rr_priority_picker #(
        .NUM_REQ (NUM_MASTERS),
        .GW      (GW)
    ) u_picker (
        .req        (req),
        .start_ptr  (rr_ptr),
        .fixed_mode (PRIORITY_MODE == PRIO_FIXED),
        .winner     (winner),
        .any_req    (any_req)
    );

    // Request line of the currently granted master; loop keeps the select in range.
    always_comb begin
        grant_req = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (GW'(i) == grant) grant_req = req[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ARB_IDLE;
            grant  <= '0;
            rr_ptr <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (any_req) begin
                        grant <= winner;
                        state <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    if (!grant_req) begin
                        // Abort: no completion, pointer keeps its value.
                        state <= ARB_IDLE;
                    end else if (bus.ready_in) begin
                        state <= ARB_IDLE;
                        if (PRIORITY_MODE == PRIO_ROUND_ROBIN) begin
                            rr_ptr <= (grant == GW'(NUM_MASTERS - 1)) ? '0 : grant + 1'b1;
                        end
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.address_out      = '0;
        bus.read_out         = 1'b0;
        bus.write_out        = 1'b0;
        bus.write_mask_out   = '0;
        bus.write_value_out  = '0;
        bus.m_read_value_out = '0;
        bus.m_ready_out      = '0;
        if (state == ARB_BUSY) begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (GW'(i) == grant) begin
                    bus.address_out     = bus.m_address_in[i*ADDR_WIDTH +: ADDR_WIDTH];
                    bus.read_out        = bus.m_read_in[i];
                    bus.write_out       = bus.m_write_in[i];
                    bus.write_mask_out  = bus.m_write_mask_in[i*MASK_WIDTH +: MASK_WIDTH];
                    bus.write_value_out = bus.m_write_value_in[i*DATA_WIDTH +: DATA_WIDTH];
                    bus.m_read_value_out[i*DATA_WIDTH +: DATA_WIDTH] = bus.read_value_in;
                    bus.m_ready_out[i]  = req[i] & bus.ready_in;
                end
            end
        end
    end

    assign state_dbg  = state;
    assign grant_dbg  = grant;
    assign rr_ptr_dbg = rr_ptr;

endmodule
